// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator for the pixel clock domain.
// It walks a (pixel_x, pixel_y) raster and produces sync pulses, a display
// enable and line/frame strobes for the frame-buffer and character renderers.
//
// All outputs come straight from flops. Sync, csync and de are decoded from
// the *next* counter values, so they change on the same edge as the counters.
// No output passes through combinational decode after a flop.
//
// Ports
//   clk          in   pixel-domain clock
//   rst          in   synchronous active-high reset
//   pix_en       in   pixel clock-enable; raster advances only when 1
//   resync       in   force raster to (0,0) on this edge (overrides pix_en)
//   pixel_x      out  current column, 0..H_TOTAL-1
//   pixel_y      out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, asserted level H_POL
//   vsync        out  vertical sync, asserted level V_POL (line aligned)
//   csync        out  composite sync, asserted (H_POL level) on hsync|vsync
//   de           out  display enable, 1 inside the visible window
//   line_start   out  one-clk strobe after the raster enters x=0
//   frame_start  out  one-clk strobe after the raster enters (0,0)
//   frame_cnt    out  completed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 29,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          resync,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows as half-open ranges [start, end).
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  // Elaboration-time guard: totals must fit in the counter width.
  if (H_TOTAL > (1 << CW)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  // Window decode helpers; values are zero-extended CW-bit counters.
  function automatic logic in_window(input logic [CW-1:0] v, input int lo,
                                     input int hi_excl);
    int vi;
    vi = int'(v);
    return (vi >= lo) && (vi < hi_excl);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  // State
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          cs_q, cs_d;
  logic          de_q, de_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;

  // Raw "this edge loads x=0 / (0,0)" events before strobe shaping.
  logic line_load;
  logic frame_load;
  logic hs_act;
  logic vs_act;

  // Next-state raster and decode
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    fcnt_d     = fcnt_q;
    line_load  = 1'b0;
    frame_load = 1'b0;

    if (resync) begin
      x_d        = '0;
      y_d        = '0;
      line_load  = 1'b1;
      frame_load = 1'b1;
    end else if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d       = '0;
        line_load = 1'b1;
        if (y_q == V_LAST) begin
          y_d        = '0;
          frame_load = 1'b1;
          fcnt_d     = fcnt_q + 8'd1;
        end else begin
          y_d = y_q + ONE;
        end
      end else begin
        x_d = x_q + ONE;
      end
    end

    // A strobe that was high last clk is not re-asserted, so back-to-back
    // resync (or a degenerate 1-pixel line) still yields isolated pulses.
    ls_d = line_load & ~ls_q;
    fs_d = frame_load & ~fs_q;

    // Decode from next-state counters so levels land with the counters.
    hs_act = in_window(x_d, HS_START, HS_END);
    vs_act = in_window(y_d, VS_START, VS_END);
    hs_d   = sync_level(hs_act, H_POL);
    vs_d   = sync_level(vs_act, V_POL);
    cs_d   = sync_level(hs_act | vs_act, H_POL);
    de_d   = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
  end

  // Registered raster and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      fcnt_q <= 8'd0;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      cs_q   <= ~H_POL;
      de_q   <= 1'b1;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      fcnt_q <= fcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      cs_q   <= cs_d;
      de_q   <= de_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign csync       = cs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances: the default 640x480 timing (A) and a tiny 14x7 raster with
// active-high syncs (B). A reference model tracks each raster as a linear
// position within the frame and derives every output arithmetically.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Configuration A (defaults)
  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 29;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  // Configuration B (small)
  localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, enA, rsA;
  logic [9:0] xA, yA;
  logic       hsA, vsA, csA, deA, lsA, fsA;
  logic [7:0] fcA;

  logic       rstB, enB, rsB;
  logic [3:0] xB, yB;
  logic       hsB, vsB, csB, deB, lsB, fsB;
  logic [7:0] fcB;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rstA), .pix_en(enA), .resync(rsA),
    .pixel_x(xA), .pixel_y(yA), .hsync(hsA), .vsync(vsA), .csync(csA),
    .de(deA), .line_start(lsA), .frame_start(fsA), .frame_cnt(fcA)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) u_dut_b (
    .clk(clk), .rst(rstB), .pix_en(enB), .resync(rsB),
    .pixel_x(xB), .pixel_y(yB), .hsync(hsB), .vsync(vsB), .csync(csB),
    .de(deB), .line_start(lsB), .frame_start(fsB), .frame_cnt(fcB)
  );

  // Packed view: {x16, y16, hs, vs, cs, de, ls, fs, fcnt8}
  logic [45:0] actA, actB;
  assign actA = {6'b0, xA, 6'b0, yA, hsA, vsA, csA, deA, lsA, fsA, fcA};
  assign actB = {12'b0, xB, 12'b0, yB, hsB, vsB, csB, deB, lsB, fsB, fcB};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // n = number of enabled pixels since the raster was last at (0,0).
  typedef struct packed {
    int   n;
    int   fcnt;
    logic ls;
    logic fs;
  } mst_t;

  function automatic mst_t mstep(input mst_t s, input logic r, input logic rs,
                                 input logic en, input int ht, input int vt);
    mst_t o;
    o = s;
    if (r) begin
      o.n = 0; o.fcnt = 0; o.ls = 1'b0; o.fs = 1'b0;
    end else if (rs) begin
      o.n  = 0;
      o.ls = !s.ls;
      o.fs = !s.fs;
    end else if (en) begin
      o.n = s.n + 1;
      if (o.n == ht * vt) begin
        o.n    = 0;
        o.fcnt = (s.fcnt + 1) % 256;
      end
      o.ls = ((o.n % ht) == 0) && !s.ls;
      o.fs = (o.n == 0) && !s.fs;
    end else begin
      o.ls = 1'b0; o.fs = 1'b0;
    end
    return o;
  endfunction

  function automatic logic [45:0] expv(input mst_t s, input int ha, input int hf,
                                       input int hsw, input int hb, input int va,
                                       input int vf, input int vsw,
                                       input logic hp, input logic vp);
    int   ht, x, y;
    logic hsa, vsa;
    ht  = ha + hf + hsw + hb;
    x   = s.n % ht;
    y   = s.n / ht;
    hsa = (x >= ha + hf) && (x < ha + hf + hsw);
    vsa = (y >= va + vf) && (y < va + vf + vsw);
    return {16'(x), 16'(y), hsa ? hp : !hp, vsa ? vp : !vp,
            (hsa || vsa) ? hp : !hp, (x < ha) && (y < va), s.ls, s.fs,
            8'(s.fcnt)};
  endfunction

  mst_t mA, mB;
  bit   armA = 1'b0, armB = 1'b0;

  always @(posedge clk) begin
    mA <= mstep(mA, rstA, rsA, enA, A_HT, A_VT);
    mB <= mstep(mB, rstB, rsB, enB, B_HT, B_VT);
    if (rstA) armA <= 1'b1;
    if (rstB) armB <= 1'b1;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (armA)
      chk("A_raster", 64'(actA),
          64'(expv(mA, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, 1'b0, 1'b0)));
    if (armB)
      chk("B_raster", 64'(actB),
          64'(expv(mB, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, 1'b1, 1'b1)));
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int ls_prev, ls_period, hs_first, hs_run, hs_len, de_fall;
    int hold_bad, consec, fc_before, waited, cs_cnt, vs_run, vs_len, vs_first;
    int fs_prev, fs_period;
    logic [9:0] prevx;
    logic       en_applied, prev_ls;

    rstA = 1'b1; enA = 1'b0; rsA = 1'b0;
    rstB = 1'b1; enB = 1'b0; rsB = 1'b0;
    repeat (3) @(negedge clk);

    chk("A_reset_state", 64'(actA), 64'({16'd0, 16'd0, 6'b111100, 8'd0}));
    chk("B_reset_state", 64'(actB), 64'({16'd0, 16'd0, 6'b000100, 8'd0}));

    // Line timing, continuous enable
    rstA = 1'b0; enA = 1'b1;
    ls_prev = -1; ls_period = -1; hs_first = -1; hs_run = 0; hs_len = -1;
    de_fall = -1;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      if (!hsA) begin
        if (hs_first < 0) hs_first = int'(xA);
        hs_run++;
      end else if (hs_run > 0 && hs_len < 0) begin
        hs_len = hs_run;
      end
      if (!deA && de_fall < 0) de_fall = int'(xA);
      if (lsA) begin
        if (ls_prev >= 0 && ls_period < 0) ls_period = c - ls_prev;
        ls_prev = c;
      end
    end
    chk("A_hsync_start_x", 64'(hs_first), 64'd656);
    chk("A_hsync_width", 64'(hs_len), 64'd96);
    chk("A_de_fall_x", 64'(de_fall), 64'd640);
    chk("A_line_period", 64'(ls_period), 64'd800);

    // Throttled: enable every second clock
    ls_prev = -1; ls_period = -1; hold_bad = 0; consec = 0; prev_ls = 1'b0;
    prevx = xA;
    for (int c = 0; c < 3400; c++) begin
      enA = (c % 2 == 0);
      en_applied = enA;
      @(negedge clk);
      if (!en_applied && xA !== prevx) hold_bad++;
      if (lsA && prev_ls) consec++;
      if (lsA) begin
        if (ls_prev >= 0 && ls_period < 0) ls_period = c - ls_prev;
        ls_prev = c;
      end
      prev_ls = lsA;
      prevx = xA;
    end
    chk("A_throttle_line_period", 64'(ls_period), 64'd1600);
    chk("A_throttle_hold_violations", 64'(hold_bad), 64'd0);
    chk("A_strobe_back_to_back", 64'(consec), 64'd0);

    // Resync in the middle of an hsync pulse
    enA = 1'b1;
    waited = 0;
    while (hsA !== 1'b0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("A_wait_hsync_bound", 64'(waited < 1000), 64'd1);
    fc_before = int'(fcA);
    rsA = 1'b1;
    @(negedge clk);
    rsA = 1'b0;
    chk("A_resync_state", 64'(actA),
        64'({16'd0, 16'd0, 6'b111111, 8'(fc_before)}));
    @(negedge clk);
    chk("A_resync_next_x", 64'(xA), 64'd1);
    chk("A_resync_next_ls", 64'(lsA), 64'd0);

    // Reset mid-line with enable held high
    repeat (300) @(negedge clk);
    rstA = 1'b1;
    repeat (3) @(negedge clk);
    chk("A_midline_reset", 64'(actA), 64'({16'd0, 16'd0, 6'b111100, 8'd0}));
    rstA = 1'b0;

    // Small configuration, continuous enable
    rstB = 1'b0; enB = 1'b1;
    fs_prev = -1; fs_period = -1; hs_first = -1; hs_run = 0; hs_len = -1;
    vs_first = -1; vs_run = 0; vs_len = -1; cs_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (hsB) begin
        if (hs_first < 0) hs_first = int'(xB);
        hs_run++;
      end else if (hs_run > 0 && hs_len < 0) begin
        hs_len = hs_run;
      end
      if (vsB) begin
        if (vs_first < 0) vs_first = int'(yB);
        vs_run++;
      end else if (vs_run > 0 && vs_len < 0) begin
        vs_len = vs_run;
      end
      if (c < 98 && csB) cs_cnt++;
      if (fsB) begin
        if (fs_prev >= 0 && fs_period < 0) fs_period = c - fs_prev;
        fs_prev = c;
      end
    end
    chk("B_hsync_start_x", 64'(hs_first), 64'd10);
    chk("B_hsync_width", 64'(hs_len), 64'd2);
    chk("B_vsync_line", 64'(vs_first), 64'd5);
    chk("B_vsync_width", 64'(vs_len), 64'd14);
    chk("B_csync_per_frame", 64'(cs_cnt), 64'd26);
    chk("B_frame_period", 64'(fs_period), 64'd98);
    chk("B_frame_cnt", 64'(fcB), 64'd3);

    // Randomised phase on both instances
    for (int c = 0; c < 20000; c++) begin
      rstA = ($urandom % 700) == 0;
      rstB = ($urandom % 500) == 0;
      rsA  = rsA ? (($urandom % 2) == 0) : (($urandom % 300) == 0);
      rsB  = rsB ? (($urandom % 2) == 0) : (($urandom % 120) == 0);
      enA  = ($urandom % 4) != 0;
      enB  = ($urandom % 4) != 0;
      @(negedge clk);
    end
    rsA = 1'b0; rsB = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
